fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the async FIFO write side among NUM_REQ requesters in the wclk domain.
- Each requester uses a valid/ready handshake.
- The arbiter drives the FIFO's winc and wdata, and throttles on the FIFO's wfull flag.
- A grant is held for a burst of up to MAX_BURST beats, which keeps related words contiguous in the FIFO.

---
 rtl/fifo_wr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin share of one async-FIFO write port among NUM_REQ valid/ready requesters, bursts up to MAX_BURST beats.
// Latency : one wclk from first valid to grant; beats then flow one per cycle, re-grant on burst end has no bubble.
// Backpres: wfull drops every req_ready and winc while holding the grant; a requester dropping valid releases at the next non-full cycle.
//
// Ports:
//   wclk, wrst_n          write-domain clock, async active-low reset
//   req_valid/req_data    per-requester valid and packed data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready             per-requester beat-accepted strobe
//   wfull                 FIFO full flag from the write-side pointer logic
//   winc, wdata           FIFO write enable and data
//   grant                 registered one-hot grant, zero when idle
//   busy                  high while a grant is held
//   beat_cnt, stall_cnt   only with FIFO_WR_ARB_BEAT_CNT_EN defined: saturating winc and stall counters
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            grant,
`ifdef FIFO_WR_ARB_BEAT_CNT_EN
  output logic [15:0]                   beat_cnt,
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [NUM_REQ-1:0]      grant_nxt;
  logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;
  logic [IDX_W-1:0]        rr_last, rr_last_nxt;

  logic [IDX_W-1:0]        g_idx;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    g_valid;
  logic                    accept;
  logic                    release_now;
  logic [IDX_W-1:0]        rr_base;
  logic [NUM_REQ-1:0]      rr_winner;

  // Round-robin pick: lowest valid index strictly above 'last', otherwise
  // wrap to the lowest valid index overall. Scanning downward lets the last
  // write in each class be the lowest index of that class.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDX_W-1:0]   last);
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] lo;
    hi = '0;
    lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        lo    = '0;
        lo[i] = 1'b1;
        if (IDX_W'(i) > last) begin
          hi    = '0;
          hi[i] = 1'b1;
        end
      end
    end
    return (hi != '0) ? hi : lo;
  endfunction

  // Decode the one-hot grant into an index and the granted data slice.
  // With no grant both stay zero, which keeps wdata at zero when idle.
  always_comb begin
    g_idx  = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_idx  = IDX_W'(i);
        g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign g_valid = |(req_valid & grant);
  assign busy    = (state == GRANT);

  assign accept    = busy & g_valid & ~wfull;
  assign winc      = accept;
  assign wdata     = g_data;
  assign req_ready = (busy & ~wfull) ? grant : '0;

  // Full never ends a burst; only a completed burst or a dropped valid does,
  // and both are judged in non-full cycles only.
  assign release_now = busy & ~wfull &
                       (~g_valid | (accept & (burst_cnt == LAST_BEAT)));

  // On release the holder becomes lowest priority for the same-edge
  // re-arbitration, so search from the current holder instead of rr_last.
  assign rr_base   = busy ? g_idx : rr_last;
  assign rr_winner = rr_pick(req_valid, rr_base);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      grant     <= '0;
      burst_cnt <= '0;
      rr_last   <= LAST_IDX;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      burst_cnt <= burst_cnt_nxt;
      rr_last   <= rr_last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    burst_cnt_nxt = burst_cnt;
    rr_last_nxt   = rr_last;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (|req_valid) begin
          grant_nxt = rr_winner;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          rr_last_nxt   = g_idx;
          burst_cnt_nxt = '0;
          if (|req_valid) begin
            grant_nxt = rr_winner;
          end else begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end else if (accept) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

`ifdef FIFO_WR_ARB_BEAT_CNT_EN
  // Saturating observability counters: beats written and cycles where the
  // granted requester was ready to send but the FIFO was full.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (winc && (beat_cnt != 16'hFFFF)) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (busy && wfull && g_valid && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : randomized + directed bench for fifo_wr_arbiter against a per-cycle reference of the arbitration rules.
// Latency : expectations are queued when inputs are applied and popped by an independent negedge monitor.
// Backpres: wfull is driven randomly so stall behaviour is exercised alongside valid drops and bursts.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic                 wclk = 1'b0;
  logic                 wrst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 wfull = 1'b0;
  logic                 winc;
  logic [DW-1:0]        wdata;
  logic [NREQ-1:0]      grant;
  logic                 busy;
`ifdef FIFO_WR_ARB_BEAT_CNT_EN
  logic [15:0]          beat_cnt;
  logic [15:0]          stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
`ifdef FIFO_WR_ARB_BEAT_CNT_EN
    .beat_cnt  (beat_cnt),
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ready;
    logic            winc;
    logic            busy;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [DW-1:0] beat_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: holder index (-1 when idle), last served index, beats in burst.
  int m_g      = -1;
  int m_last   = NREQ - 1;
  int m_cnt    = 0;
  int m_beats  = 0;
  int m_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g      = -1;
    m_last   = NREQ - 1;
    m_cnt    = 0;
    m_beats  = 0;
    m_stalls = 0;
  endtask

  // Apply one cycle of inputs and queue what the arbiter must show in it.
  task automatic drive_cycle(input logic [NREQ-1:0] v, input logic full);
    cyc_t e;
    logic acc;
    @(posedge wclk);
    #1;
    req_valid = v;
    wfull     = full;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    e = '0;
    if (m_g >= 0) begin
      e.grant = NREQ'(1 << m_g);
      e.busy  = 1'b1;
      e.ready = full ? '0 : NREQ'(1 << m_g);
      acc     = v[m_g] && !full;
      e.winc  = acc;
      if (acc) begin
        beat_q.push_back(req_data[m_g*DW +: DW]);
        m_beats++;
      end
      if (full && v[m_g]) m_stalls++;
      if (!full) begin
        if (acc) m_cnt++;
        if (!v[m_g] || m_cnt == MB) begin
          m_last = m_g;
          m_g    = pick(v, m_last);
          m_cnt  = 0;
        end
      end
    end else begin
      m_g   = pick(v, m_last);
      m_cnt = 0;
    end
    cyc_q.push_back(e);
  endtask

  task automatic repeat_cycle(input logic [NREQ-1:0] v, input logic full, input int n);
    for (int i = 0; i < n; i++) drive_cycle(v, full);
  endtask

  // Monitor: decoupled from stimulus, pops on every observed beat and cycle.
  initial begin
    cyc_t e;
    forever begin
      @(negedge wclk);
      if (winc) begin
        if (beat_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_winc: got winc=1 wdata=%0h, expected no beat (t=%0t)", wdata, $time);
        end else begin
          chk("wdata", 32'(wdata), 32'(beat_q.pop_front()));
        end
      end
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("req_ready", 32'(req_ready), 32'(e.ready));
        chk("winc", 32'(winc), 32'(e.winc));
        chk("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] rv;
    // Reset state, checked while reset is still asserted.
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    #9 wrst_n = 1'b1;

    // Single requester streaming: bursts of MB back to back with no bubble.
    repeat_cycle(4'b0001, 1'b0, 10);
    repeat_cycle(4'b0000, 1'b0, 2);

    // Requester 2 granted, FIFO full for 5 cycles after 2 beats, then rotate to 3.
    repeat_cycle(4'b1100, 1'b0, 3);
    repeat_cycle(4'b1100, 1'b1, 5);
    repeat_cycle(4'b1100, 1'b0, 4);
`ifdef FIFO_WR_ARB_BEAT_CNT_EN
    @(negedge wclk);
    chk("stall_cnt_s3", 32'(stall_cnt), 32'd5);
    chk("beat_cnt_s3", 32'(beat_cnt), 32'(m_beats));
`endif
    repeat_cycle(4'b0000, 1'b0, 2);

    // All requesting: full rotation of MB-beat bursts.
    repeat_cycle(4'b1111, 1'b0, 20);

    // Requester 1 drops after one beat while requester 3 waits.
    repeat_cycle(4'b0000, 1'b0, 2);
    repeat_cycle(4'b1010, 1'b0, 1);
    repeat_cycle(4'b1010, 1'b0, 1);
    repeat_cycle(4'b1000, 1'b0, 3);
    repeat_cycle(4'b0000, 1'b0, 2);

    // Reset mid-burst: outputs must clear immediately.
    repeat_cycle(4'b1111, 1'b0, 3);
    @(negedge wclk);
    #1;
    wrst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    model_reset();
    #1;
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_winc", 32'(winc), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge wclk);
    #3 wrst_n = 1'b1;
    repeat_cycle(4'b1111, 1'b0, 6);

    // Randomized traffic with random FIFO-full throttling.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) rv[i] = ($urandom_range(3) != 0);
      drive_cycle(rv, ($urandom_range(4) == 0));
    end

    repeat_cycle(4'b0000, 1'b0, 4);
    @(negedge wclk);
    #1;
    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("cycles_left", 32'(cyc_q.size()), 32'd0);
`ifdef FIFO_WR_ARB_BEAT_CNT_EN
    chk("beat_cnt", 32'(beat_cnt), 32'(m_beats));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
